muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 33 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_unit_if                                               |
// | Description : Handshake and operand bundle between the execute-stage       |
// |               controller and the iterative RV32M multiply/divide unit.     |
// | Signals     : start, srcA, srcB, MDControl  (controller -> unit)           |
// |               busy, done, MDResult, Zero    (unit -> controller)           |
// | Modports    : master = controller side, slave = muldiv_unit side           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [2:0]      MDControl;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] MDResult;
  logic            Zero;

  modport master (
    output start, srcA, srcB, MDControl,
    input  busy, done, MDResult, Zero
  );

  modport slave (
    input  start, srcA, srcB, MDControl,
    output busy, done, MDResult, Zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                  |
// | Description : Iterative RV32M multiply/divide unit, fixed 34-cycle         |
// |               start-to-done latency (1 accept + 32 iterations + 1 fix).    |
// |               Multiplies use radix-2 shift-add on operand magnitudes;      |
// |               divides use restoring division on magnitudes; signs are      |
// |               re-applied in the final FIX cycle.                           |
// | Ports       : clk   - rising-edge clock                                    |
// |               reset - synchronous active-high reset                        |
// |               bus   - muldiv_unit_if.slave (start/operands/op in,          |
// |                       busy/done/MDResult/Zero out)                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;          // sign of operand A (0 if unsigned op)
  logic              sb_q, sb_d;          // sign of operand B (0 if unsigned op)
  logic [XLEN-1:0]   hi_q, hi_d;          // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;          // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]   mcand_q, mcand_d;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Datapath intermediates
  logic              a_signed, b_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.MDControl)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 begin a_signed = 1'b1; end
      default:                ;
    endcase
    mag_a = (a_signed && bus.srcA[XLEN-1]) ? (~bus.srcA + 1'b1) : bus.srcA;
    mag_b = (b_signed && bus.srcB[XLEN-1]) ? (~bus.srcB + 1'b1) : bus.srcB;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole 2*XLEN accumulator right.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

    // Restoring step: the partial remainder is always < divisor, so after the
    // subtraction it fits in XLEN bits and modular XLEN-bit subtraction is exact.
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});

    prod_s = (sa_q ^ sb_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quo_s  = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
    // Remainder follows the dividend sign. With a zero divisor the magnitude
    // algorithm leaves |A| here, so re-applying A's sign returns A unchanged.
    rem_s  = sa_q ? (~hi_q + 1'b1) : hi_q;

    case (op_q)
      3'b000:                 fix_result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = (mcand_q == '0) ? '1 : quo_s;
      default:                fix_result = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          op_d    = bus.MDControl;
          sa_d    = a_signed & bus.srcA[XLEN-1];
          sb_d    = b_signed & bus.srcB[XLEN-1];
          cnt_d   = '0;
          hi_d    = '0;
          if (bus.MDControl[2]) begin
            lo_d    = mag_a;
            mcand_d = mag_b;
          end else begin
            lo_d    = mag_b;
            mcand_d = mag_a;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[2]) begin
          hi_d = div_ge ? (div_shift[XLEN-1:0] - mcand_q) : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.MDResult = result_q;
  assign bus.Zero     = (result_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_muldiv_unit                                               |
// | Description : Self-checking bench for muldiv_unit. Directed corner cases   |
// |               plus random operations against an arithmetic reference.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic        [63:0] p;
    logic signed [31:0] as_v, bs_v, q;
    logic        [31:0] r;
    as_v = a;
    bs_v = b;
    r = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; p = pa * pb; r = p[63:32]; end
      3'd2: begin pa = {{32{a[31]}}, a}; pb = {32'b0, b}; p = pa * pb; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin q = as_v / bs_v; r = q; end
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
        else begin q = as_v % bs_v; r = q; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Waits for done after the accepting edge; lat = negedges counted (-1 on
  // timeout), hs_bad = cycles where busy/done disagreed with the window.
  task automatic wait_done(output logic [31:0] res, output logic z, output int lat, output int hs_bad);
    lat = -1; hs_bad = 0; res = 'x; z = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        if (bus.busy !== 1'b0) hs_bad++;
        res = bus.MDResult;
        z   = bus.Zero;
        break;
      end else if (bus.busy !== 1'b1) begin
        hs_bad++;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat, output int hs_bad);
    @(negedge clk);
    bus.MDControl = op; bus.srcA = a; bus.srcB = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Inputs change after acceptance; the unit must ignore them.
    bus.srcA = $urandom; bus.srcB = $urandom; bus.MDControl = 3'($urandom_range(0, 7));
    wait_done(res, z, lat, hs_bad);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.MDResult !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.MDResult); end
    checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b want=1", bus.Zero); end
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic [31:0] res; logic z; int lat, hs;
    run_op(3'd0, 32'd7, 32'd6, res, z, lat, hs);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d want=34", lat); end
    checks++; if (hs !== 0) begin errors++; $display("FAIL mul_busy_window bad_cycles=%0d want=0", hs); end
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_7x6 got=%h want=%h", res, 32'd42); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL mul_zero got=%b want=0", z); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops[14];
    logic [31:0] as[14], bs[14], exp[14];
    logic [31:0] res; logic z; int lat, hs;
    ops = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
            32'h80000000, 32'h80000000, 32'h12345678, 32'h12345678,
            32'h80000000, 32'h80000000};
    bs  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    exp = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE,
            32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001,
            32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h12345678,
            32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 14; i++) begin
      run_op(ops[i], as[i], bs[i], res, z, lat, hs);
      checks++;
      if (res !== exp[i] || lat !== 34) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=34", i, ops[i], as[i], bs[i], res, lat, exp[i]);
      end
      checks++;
      if (z !== (exp[i] == 32'h0)) begin errors++; $display("FAIL directed_zero[%0d] got=%b want=%b", i, z, exp[i] == 32'h0); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, e, res; logic z; int lat, hs;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      e = ref_md(op, a, b);
      run_op(op, a, b, res, z, lat, hs);
      checks++;
      if (res !== e || z !== (e == 32'h0) || lat !== 34 || hs !== 0) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h z=%b lat=%0d hs=%0d want=%h", i, op, a, b, res, z, lat, hs, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] res; logic z; int lat, hs;
    lat = -1; hs = 0; res = 'x; z = 1'bx;
    @(negedge clk);
    bus.MDControl = 3'd0; bus.srcA = 32'd1000; bus.srcB = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 10) begin
        bus.MDControl = 3'd5; bus.srcA = 32'd99; bus.srcB = 32'd7; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = n; res = bus.MDResult; z = bus.Zero;
        break;
      end else if (bus.busy !== 1'b1) begin
        hs++;
      end
    end
    bus.start = 1'b0;
    checks++; if (res !== 32'd3000 || lat !== 34) begin errors++; $display("FAIL busy_ignore got=%h lat=%0d want=%h lat=34", res, lat, 32'd3000); end
    checks++; if (hs !== 0) begin errors++; $display("FAIL busy_ignore_window bad_cycles=%0d want=0", hs); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_no_restart got=%b want=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic z; int lat, hs;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, res, z, lat, hs);
    checks++; if (res !== 32'hFFFFFFFE || lat !== 34) begin errors++; $display("FAIL b2b_first got=%h lat=%0d want=fffffffe lat=34", res, lat); end
    // Still in the done cycle: present the next request now.
    bus.MDControl = 3'd7; bus.srcA = 32'd100; bus.srcB = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(res, z, lat, hs);
    checks++; if (res !== 32'd2 || lat !== 34) begin errors++; $display("FAIL b2b_second got=%h lat=%0d want=2 lat=34", res, lat); end
    checks++; if (hs !== 0) begin errors++; $display("FAIL b2b_window bad_cycles=%0d want=0", hs); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res; logic z; int lat, hs, seen;
    @(negedge clk);
    bus.MDControl = 3'd4; bus.srcA = 32'd500; bus.srcB = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", bus.done); end
    checks++; if (bus.MDResult !== 32'h0) begin errors++; $display("FAIL abort_result got=%h want=0", bus.MDResult); end
    checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL abort_zero got=%b want=1", bus.Zero); end
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done activity_cycles=%0d want=0", seen); end
    run_op(3'd0, 32'd3, 32'd5, res, z, lat, hs);
    checks++; if (res !== 32'd15 || lat !== 34) begin errors++; $display("FAIL abort_then_mul got=%h lat=%0d want=f lat=34", res, lat); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.srcA = '0;
    bus.srcB = '0;
    bus.MDControl = '0;
    test_reset();
    test_mul_basic();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
